// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for one shared combinational ALU
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   req_valid/ready   per-requester request handshake (bit i = requester i)
//   req_op1/op2       packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_sel           packed ALU select codes, requester i at [i*4 +: 4]
//   rsp_valid/ready   per-requester response handshake
//   rsp_result/err    shared response payload, qualified by rsp_valid
//   alu_op1/op2/sel   registered operands driven to the external ALU
//   alu_result        combinational result back from the ALU

module alu_arbiter #(
  parameter int         WIDTH      = 32,
  parameter logic [3:0] SEL_DIVIDE = 4'b0011
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*WIDTH-1:0]   req_op1,
  input  logic [2*WIDTH-1:0]   req_op2,
  input  logic [7:0]           req_sel,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [WIDTH-1:0]     rsp_result,
  output logic                 rsp_err,
  output logic [WIDTH-1:0]     alu_op1,
  output logic [WIDTH-1:0]     alu_op2,
  output logic [3:0]           alu_sel,
  input  logic [WIDTH-1:0]     alu_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_n;
  logic               prio;
  logic               owner;
  logic [WIDTH-1:0]   op1_q;
  logic [WIDTH-1:0]   op2_q;
  logic [3:0]         sel_q;
  logic [WIDTH-1:0]   result_q;
  logic               err_q;

  logic               grant_any;
  logic               grant;
  logic               div_zero;

  // Round-robin pick: the favoured requester wins if valid, otherwise the other one.
  always_comb begin
    grant_any = 1'b0;
    grant     = prio;
    if (req_valid[prio]) begin
      grant_any = 1'b1;
      grant     = prio;
    end else if (req_valid[~prio]) begin
      grant_any = 1'b1;
      grant     = ~prio;
    end
  end

  assign div_zero = (sel_q == SEL_DIVIDE) && (op2_q == '0);

  always_comb begin
    state_n   = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    unique case (state)
      IDLE: begin
        // Ready is suppressed while rst is high so nothing looks accepted during reset.
        if (grant_any && !rst) begin
          req_ready[grant] = 1'b1;
          state_n          = EXEC;
        end
      end
      EXEC: begin
        state_n = RESP;
      end
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prio     <= 1'b0;
      owner    <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      sel_q    <= 4'b0000;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            owner <= grant;
            op1_q <= grant ? req_op1[WIDTH +: WIDTH] : req_op1[0 +: WIDTH];
            op2_q <= grant ? req_op2[WIDTH +: WIDTH] : req_op2[0 +: WIDTH];
            sel_q <= grant ? req_sel[4 +: 4] : req_sel[0 +: 4];
          end
        end
        EXEC: begin
          // A divide by zero returns a clean zero rather than whatever the ALU produces.
          result_q <= div_zero ? '0 : alu_result;
          err_q    <= div_zero;
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            prio <= ~owner;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_sel    = sel_q;
  assign rsp_result = result_q;
  assign rsp_err    = err_q;

endmodule
